// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory-access pipeline stage between EX and WB.
//
// Accepts one instruction at a time from EX. Non-memory instructions pass
// straight to the MEM/WB registers (one cycle, full throughput). Loads and
// stores run a req/ack transaction against the data RAM with byte-lane
// steering; load data is extracted from its lane and sign/zero extended.
// A combinational forward path presents the incoming ALU result to ID.
//
// Optional feature (compile-time macro MEM_MISALIGN_TRAP_EN):
//   defined   : misaligned or illegal-size accesses skip the RAM and
//               complete after one cycle with misalign_o pulsed.
//   undefined : misalign_o is always 0; offending low address bits are
//               cleared and illegal sizes act as a word access.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   valid_i / ready_o / stall_o  EX handshake (ready only in IDLE)
//   rd_addr_i, wreg_i, wdata_i   destination, write flag, ALU result/address
//   store_data_i                 store source data
//   is_load_i, is_store_i        access type
//   funct3_i                     access size and signedness
//   dram_req_o, dram_we_o        RAM request and direction
//   dram_addr_o, dram_be_o       word address and byte enables
//   dram_wdata_o                 lane-replicated store data
//   dram_ack_i, dram_rdata_i     RAM completion and read word
//   valid_o, rd_addr_o, wreg_o,
//   wdata_o                      registered MEM/WB fields
//   mem_back_*                   combinational forward to ID
//   misalign_o                   misaligned-access pulse
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  wreg_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W-1:0]     store_data_i,
  input  logic                  is_load_i,
  input  logic                  is_store_i,
  input  logic [2:0]            funct3_i,
  output logic                  dram_req_o,
  output logic                  dram_we_o,
  output logic [ADDR_W-1:0]     dram_addr_o,
  output logic [DATA_W/8-1:0]   dram_be_o,
  output logic [DATA_W-1:0]     dram_wdata_o,
  input  logic                  dram_ack_i,
  input  logic [DATA_W-1:0]     dram_rdata_i,
  output logic                  valid_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [REG_ADDR_W-1:0] mem_back_rd_addr_o,
  output logic                  mem_back_wreg_o,
  output logic [DATA_W-1:0]     mem_back_wdata_o,
  output logic                  stall_o,
  output logic                  misalign_o
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic                mem_op;
  logic [1:0]          size_code;   // log2 of access size in bytes
  logic                sign_ext;
  logic [ADDR_W-1:0]   off_mask;
  logic [ADDR_W-1:0]   eff_addr;
  logic [LANE_W-1:0]   lane;
  logic [NB-1:0]       be_next;
  logic [DATA_W-1:0]   store_rep;
  logic                trap;

  // Access shape remembered for the load extraction at ack time.
  logic [1:0]          size_q;
  logic                sign_q;
  logic [LANE_W-1:0]   lane_q;

  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   load_mask;
  logic [DATA_W-1:0]   load_top;
  logic [DATA_W-1:0]   load_data;

  assign mem_op = is_load_i | is_store_i;

  // Size decode. Anything not recognised for this width behaves as a
  // signed word access.
  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    size_code = 2'd2;
    sign_ext  = 1'b1;
    case (funct3_i)
      3'b000:  size_code = 2'd0;
      3'b001:  size_code = 2'd1;
      3'b100:  begin size_code = 2'd0; sign_ext = 1'b0; end
      3'b101:  begin size_code = 2'd1; sign_ext = 1'b0; end
      3'b011:  if (DATA_W == 64) size_code = 2'd3;
      3'b110:  if (DATA_W == 64) sign_ext = 1'b0;
      default: ;
    endcase
  end

  // Low address bits that must be zero for natural alignment.
  assign off_mask = ADDR_W'((32'd1 << size_code) - 32'd1);
  assign eff_addr = wdata_i[ADDR_W-1:0] & ~off_mask;
  assign lane     = eff_addr[LANE_W-1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  logic legal;
  always_comb begin
    legal = 1'b1;
    case (funct3_i)
      3'b011, 3'b110: legal = (DATA_W == 64);
      3'b111:         legal = 1'b0;
      default:        ;
    endcase
  end
  assign trap = mem_op & (~legal | (|(wdata_i[ADDR_W-1:0] & off_mask)));
`else
  assign trap = 1'b0;
`endif

  // Store data replicated so every lane carries the value; the byte enables
  // pick the lanes actually written.
  always_comb begin
    case (size_code)
      2'd0:    store_rep = {NB{store_data_i[7:0]}};
      2'd1:    store_rep = {(NB/2){store_data_i[15:0]}};
      2'd2:    store_rep = {(NB/4){store_data_i[31:0]}};
      default: store_rep = store_data_i;
    endcase
  end

  assign be_next = NB'((32'd1 << (32'd1 << size_code)) - 32'd1) << lane;

  // Load extraction: shift the lane down, then keep the access-sized field
  // and fill the upper bits from its top bit or with zeros. A full-width
  // access shifts the 1 out entirely, which yields an all-ones mask.
  assign shifted   = dram_rdata_i >> {lane_q, 3'b000};
  assign load_mask = (DATA_W'(1) << (32'd8 << size_q)) - DATA_W'(1);
  assign load_top  = load_mask & ~(load_mask >> 1);
  assign load_data = (sign_q && |(shifted & load_top)) ? (shifted | ~load_mask)
                                                       : (shifted & load_mask);

  assign ready_o    = (state == IDLE);
  assign stall_o    = ~ready_o;
  assign dram_req_o = (state == ACCESS);

  // A load result does not exist yet in this cycle, so it is never forwarded.
  assign mem_back_rd_addr_o = rd_addr_i;
  assign mem_back_wdata_o   = wdata_i;
  assign mem_back_wreg_o    = wreg_i & valid_i & ~is_load_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      valid_o      <= 1'b0;
      misalign_o   <= 1'b0;
      rd_addr_o    <= '0;
      wreg_o       <= 1'b0;
      wdata_o      <= '0;
      dram_we_o    <= 1'b0;
      dram_addr_o  <= '0;
      dram_be_o    <= '0;
      dram_wdata_o <= '0;
      size_q       <= '0;
      sign_q       <= 1'b0;
      lane_q       <= '0;
    end else begin
      valid_o    <= 1'b0;
      misalign_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            rd_addr_o <= rd_addr_i;
            wdata_o   <= wdata_i;
            if (!mem_op) begin
              wreg_o  <= wreg_i;
              valid_o <= 1'b1;
            end else if (trap) begin
              wreg_o     <= 1'b0;
              valid_o    <= 1'b1;
              misalign_o <= 1'b1;
            end else begin
              wreg_o       <= wreg_i & is_load_i;
              dram_we_o    <= is_store_i;
              dram_addr_o  <= {eff_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
              dram_be_o    <= be_next;
              dram_wdata_o <= store_rep;
              size_q       <= size_code;
              sign_q       <= sign_ext;
              lane_q       <= lane;
              state        <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (dram_ack_i) begin
            if (!dram_we_o) wdata_o <= load_data;
            valid_o   <= 1'b1;
            dram_we_o <= 1'b0;
            dram_be_o <= '0;
            state     <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
// Two instances (DATA_W=32 and DATA_W=64) share the instruction inputs;
// each has its own valid and ack. A byte-level reference model computes the
// expected RAM request and load result for every access. Expectations for
// misaligned accesses follow MEM_MISALIGN_TRAP_EN if it is defined.
// ---------------------------------------------------------------------------
module tb_mem_stage;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic        trap;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [63:0] ldata;
  } exp_t;

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared instruction inputs
  logic        v32, v64, ack32, ack64;
  logic [4:0]  rd_addr;
  logic        wreg, is_ld, is_st;
  logic [63:0] wdata, sdata, rdata;
  logic [2:0]  f3;

  // 32-bit instance outputs
  logic        r32, req32, we32, val32, wr32, bwr32, st32, mis32;
  logic [31:0] addr32, dwd32, res32, bwd32;
  logic [3:0]  be32;
  logic [4:0]  rd32, brd32;

  // 64-bit instance outputs
  logic        r64, req64, we64, val64, wr64, bwr64, st64, mis64;
  logic [31:0] addr64;
  logic [63:0] dwd64, res64, bwd64;
  logic [7:0]  be64;
  logic [4:0]  rd64, brd64;

  mem_stage #(.DATA_W(32), .REG_ADDR_W(5), .ADDR_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .valid_i(v32), .ready_o(r32),
    .rd_addr_i(rd_addr), .wreg_i(wreg), .wdata_i(wdata[31:0]),
    .store_data_i(sdata[31:0]), .is_load_i(is_ld), .is_store_i(is_st),
    .funct3_i(f3), .dram_req_o(req32), .dram_we_o(we32), .dram_addr_o(addr32),
    .dram_be_o(be32), .dram_wdata_o(dwd32), .dram_ack_i(ack32),
    .dram_rdata_i(rdata[31:0]), .valid_o(val32), .rd_addr_o(rd32),
    .wreg_o(wr32), .wdata_o(res32), .mem_back_rd_addr_o(brd32),
    .mem_back_wreg_o(bwr32), .mem_back_wdata_o(bwd32), .stall_o(st32),
    .misalign_o(mis32)
  );

  mem_stage #(.DATA_W(64), .REG_ADDR_W(5), .ADDR_W(32)) u_dut64 (
    .clk(clk), .rst(rst), .valid_i(v64), .ready_o(r64),
    .rd_addr_i(rd_addr), .wreg_i(wreg), .wdata_i(wdata),
    .store_data_i(sdata), .is_load_i(is_ld), .is_store_i(is_st),
    .funct3_i(f3), .dram_req_o(req64), .dram_we_o(we64), .dram_addr_o(addr64),
    .dram_be_o(be64), .dram_wdata_o(dwd64), .dram_ack_i(ack64),
    .dram_rdata_i(rdata), .valid_o(val64), .rd_addr_o(rd64),
    .wreg_o(wr64), .wdata_o(res64), .mem_back_rd_addr_o(brd64),
    .mem_back_wreg_o(bwr64), .mem_back_wdata_o(bwd64), .stall_o(st64),
    .misalign_o(mis64)
  );

  // View of whichever instance is under test, widened to 64 bits.
  logic        wide;
  logic        ob_ready, ob_req, ob_we, ob_valid, ob_wreg, ob_bwreg, ob_stall, ob_mis;
  logic [31:0] ob_addr;
  logic [7:0]  ob_be;
  logic [63:0] ob_dwd, ob_res, ob_bwd;
  logic [4:0]  ob_rd, ob_brd;

  always_comb begin
    if (wide) begin
      ob_ready = r64; ob_req = req64; ob_we = we64; ob_valid = val64;
      ob_wreg = wr64; ob_bwreg = bwr64; ob_stall = st64; ob_mis = mis64;
      ob_addr = addr64; ob_be = be64; ob_dwd = dwd64; ob_res = res64;
      ob_bwd = bwd64; ob_rd = rd64; ob_brd = brd64;
    end else begin
      ob_ready = r32; ob_req = req32; ob_we = we32; ob_valid = val32;
      ob_wreg = wr32; ob_bwreg = bwr32; ob_stall = st32; ob_mis = mis32;
      ob_addr = addr32; ob_be = {4'b0, be32}; ob_dwd = {32'b0, dwd32};
      ob_res = {32'b0, res32}; ob_bwd = {32'b0, bwd32};
      ob_rd = rd32; ob_brd = brd32;
    end
  end

  // Reference model: works byte by byte on a RAM word of nb bytes.
  function automatic exp_t model(input int nb, input logic [31:0] a,
                                 input logic [2:0] f, input logic [63:0] sd,
                                 input logic [63:0] rw);
    exp_t        e;
    int          sz, lane;
    bit          sgn, legal;
    logic [31:0] ea;
    logic [63:0] v;
    legal = 1'b1; sz = 4; sgn = 1'b1;
    case (f)
      3'd0: begin sz = 1; sgn = 1'b1; end
      3'd1: begin sz = 2; sgn = 1'b1; end
      3'd2: begin sz = 4; sgn = 1'b1; end
      3'd4: begin sz = 1; sgn = 1'b0; end
      3'd5: begin sz = 2; sgn = 1'b0; end
      3'd3: if (nb == 8) begin sz = 8; sgn = 1'b1; end else legal = 1'b0;
      3'd6: if (nb == 8) begin sz = 4; sgn = 1'b0; end else legal = 1'b0;
      default: legal = 1'b0;
    endcase
    if (!legal) begin sz = 4; sgn = 1'b1; end
    e.trap  = TRAP_EN && (!legal || (a % sz) != 0);
    ea      = a - (a % sz);
    lane    = int'(ea % nb);
    e.addr  = ea - (ea % nb);
    e.be    = '0;
    e.wdata = '0;
    for (int i = 0; i < nb; i++) begin
      if (i >= lane && i < lane + sz) e.be[i] = 1'b1;
      e.wdata[8*i +: 8] = sd[8*(i % sz) +: 8];
    end
    v = '0;
    for (int k = 0; k < sz; k++) v[8*k +: 8] = rw[8*(lane+k) +: 8];
    if (sz < 8 && sgn && v[8*sz-1]) v = v | ~((64'd1 << (8*sz)) - 64'd1);
    if (nb == 4) v = v & 64'h0000_0000_FFFF_FFFF;
    e.ldata = v;
    return e;
  endfunction

  // One instruction through the instance selected by w. nwait = ack-low
  // cycles spent in ACCESS before the ack cycle. use_want overrides the
  // model's load result with a hand-derived constant.
  task automatic run_op(input bit w, input logic [4:0] rd, input bit wr,
                        input logic [63:0] wd, input logic [63:0] sd,
                        input bit ld, input bit st, input logic [2:0] f,
                        input int nwait, input logic [63:0] rw,
                        input bit use_want, input logic [63:0] want,
                        input string tag);
    exp_t        e;
    logic [63:0] wmask, exp_ld;
    bit          mem;
    int          stalls;
    wmask  = w ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    e      = model(w ? 8 : 4, wd[31:0], f, sd, rw);
    exp_ld = use_want ? want : e.ldata;
    mem    = ld | st;
    wide = w; rd_addr = rd; wreg = wr; wdata = wd; sdata = sd;
    is_ld = ld; is_st = st; f3 = f;
    if (w) v64 = 1'b1; else v32 = 1'b1;
    #1;
    checks++;
    if ({ob_ready, ob_brd, ob_bwreg, ob_bwd} !== {1'b1, rd, wr & ~ld, wd & wmask}) begin
      errors++;
      $display("FAIL %s accept/forward: got ready=%b rd=%0d wreg=%b wd=%h want ready=1 rd=%0d wreg=%b wd=%h",
               tag, ob_ready, ob_brd, ob_bwreg, ob_bwd, rd, wr & ~ld, wd & wmask);
    end
    @(posedge clk); #1;
    v32 = 1'b0; v64 = 1'b0;
    if (!mem || e.trap) begin
      checks++;
      if ({ob_valid, ob_rd, ob_wreg, ob_mis, ob_req, ob_stall} !==
          {1'b1, rd, wr & ~mem, mem, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL %s result: got valid=%b rd=%0d wreg=%b mis=%b req=%b stall=%b want valid=1 rd=%0d wreg=%b mis=%b req=0 stall=0",
                 tag, ob_valid, ob_rd, ob_wreg, ob_mis, ob_req, ob_stall, rd, wr & ~mem, mem);
      end
      if (!mem) begin
        checks++;
        if (ob_res !== (wd & wmask)) begin
          errors++;
          $display("FAIL %s wdata_o: got %h want %h", tag, ob_res, wd & wmask);
        end
      end
      @(posedge clk); #1;
      checks++;
      if ({ob_valid, ob_mis} !== 2'b00) begin
        errors++;
        $display("FAIL %s pulse: got valid=%b mis=%b want 0 0", tag, ob_valid, ob_mis);
      end
    end else begin
      stalls = 0;
      for (int c = 0; c <= nwait; c++) begin
        if (ob_stall) stalls++;
        checks++;
        if ({ob_req, ob_we, ob_addr, ob_valid} !== {1'b1, st, e.addr, 1'b0}) begin
          errors++;
          $display("FAIL %s request c%0d: got req=%b we=%b addr=%h valid=%b want req=1 we=%b addr=%h valid=0",
                   tag, c, ob_req, ob_we, ob_addr, ob_valid, st, e.addr);
        end
        if (st) begin
          checks++;
          if ({ob_be, ob_dwd} !== {e.be, e.wdata & wmask}) begin
            errors++;
            $display("FAIL %s store lanes c%0d: got be=%b wdata=%h want be=%b wdata=%h",
                     tag, c, ob_be, ob_dwd, e.be, e.wdata & wmask);
          end
        end
        if (c == nwait) begin
          rdata = rw;
          if (w) ack64 = 1'b1; else ack32 = 1'b1;
        end
        @(posedge clk); #1;
        ack32 = 1'b0; ack64 = 1'b0;
      end
      if (ob_stall) stalls++;
      checks++;
      if ({ob_valid, ob_rd, ob_wreg, ob_mis, ob_req} !== {1'b1, rd, wr & ld, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL %s completion: got valid=%b rd=%0d wreg=%b mis=%b req=%b want valid=1 rd=%0d wreg=%b mis=0 req=0",
                 tag, ob_valid, ob_rd, ob_wreg, ob_mis, ob_req, rd, wr & ld);
      end
      if (ld) begin
        checks++;
        if (ob_res !== exp_ld) begin
          errors++;
          $display("FAIL %s load data: got %h want %h", tag, ob_res, exp_ld);
        end
      end
      @(posedge clk); #1;
      checks++;
      if ({stalls, ob_ready, ob_valid} !== {nwait + 2, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL %s stall/return: got stalls=%0d ready=%b valid=%b want stalls=%0d ready=1 valid=0",
                 tag, stalls, ob_ready, ob_valid, nwait + 2);
      end
    end
  endtask

  task automatic test_reset;
    wide = 1'b0;
    checks++;
    if ({ob_ready, ob_stall, ob_req, ob_we, ob_valid, ob_wreg, ob_mis, ob_rd, ob_res, ob_addr, ob_be}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 32'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset32: got ready=%b stall=%b req=%b we=%b valid=%b wreg=%b mis=%b rd=%0d wd=%h addr=%h be=%b want ready=1 rest 0",
               ob_ready, ob_stall, ob_req, ob_we, ob_valid, ob_wreg, ob_mis, ob_rd, ob_res, ob_addr, ob_be);
    end
    wide = 1'b1; #1;
    checks++;
    if ({ob_ready, ob_req, ob_valid, ob_wreg, ob_res} !== {1'b1, 1'b0, 1'b0, 1'b0, 64'd0}) begin
      errors++;
      $display("FAIL reset64: got ready=%b req=%b valid=%b wreg=%b wd=%h want 1 0 0 0 0",
               ob_ready, ob_req, ob_valid, ob_wreg, ob_res);
    end
    wide = 1'b0;
  endtask

  task automatic test_alu;
    run_op(0, 5'd5, 1, 64'h1234, 64'd0, 0, 0, 3'd0, 0, 64'd0, 0, 64'd0, "alu");
    run_op(0, 5'd9, 0, 64'hDEAD_BEEF, 64'd0, 0, 0, 3'd2, 0, 64'd0, 0, 64'd0, "alu_nowreg");
  endtask

  task automatic test_load;
    run_op(0, 5'd3, 1, 64'h1003, 64'd0, 1, 0, 3'b000, 3, 64'h80FF_FF00, 1, 64'hFFFF_FF80, "lb");
    run_op(0, 5'd4, 1, 64'h1003, 64'd0, 1, 0, 3'b100, 3, 64'h80FF_FF00, 1, 64'h0000_0080, "lbu");
    run_op(0, 5'd6, 1, 64'h1002, 64'd0, 1, 0, 3'b001, 0, 64'h8001_7F00, 1, 64'hFFFF_8001, "lh");
    run_op(0, 5'd7, 1, 64'h1004, 64'd0, 1, 0, 3'b010, 1, 64'h8765_4321, 1, 64'h8765_4321, "lw");
  endtask

  task automatic test_store;
    run_op(0, 5'd8, 1, 64'h2002, 64'hABCD, 0, 1, 3'b001, 2, 64'd0, 0, 64'd0, "sh");
    run_op(0, 5'd8, 1, 64'h2001, 64'h5A, 0, 1, 3'b000, 0, 64'd0, 0, 64'd0, "sb");
  endtask

  task automatic test_misalign;
    run_op(0, 5'd10, 1, 64'h3001, 64'd0, 1, 0, 3'b010, 1, 64'h1122_3344, 0, 64'd0, "lw_mis");
    run_op(0, 5'd11, 1, 64'h3003, 64'h7777, 0, 1, 3'b001, 0, 64'd0, 0, 64'd0, "sh_mis");
    run_op(0, 5'd12, 1, 64'h3000, 64'd0, 1, 0, 3'b011, 0, 64'hCAFE_F00D, 0, 64'd0, "ld_on_32");
  endtask

  task automatic test_wide;
    run_op(1, 5'd13, 1, 64'h100C, 64'd0, 1, 0, 3'b110, 1, 64'hFFFF_FFFF_0000_0000, 1,
           64'h0000_0000_FFFF_FFFF, "lwu64");
    run_op(1, 5'd14, 1, 64'h1008, 64'd0, 1, 0, 3'b011, 0, 64'h0123_4567_89AB_CDEF, 1,
           64'h0123_4567_89AB_CDEF, "ld64");
    run_op(1, 5'd15, 1, 64'h100C, 64'd0, 1, 0, 3'b010, 0, 64'h8000_0000_0000_0000, 1,
           64'hFFFF_FFFF_8000_0000, "lw64");
    run_op(1, 5'd16, 0, 64'h1005, 64'h3C, 0, 1, 3'b000, 1, 64'd0, 0, 64'd0, "sb64");
  endtask

  task automatic test_rst_access;
    wide = 1'b0; rd_addr = 5'd17; wreg = 1'b1; wdata = 64'h4000; is_ld = 1'b1;
    is_st = 1'b0; f3 = 3'b010; v32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0;
    checks++;
    if (ob_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_access pre: got req=%b want 1", ob_req);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ob_req, ob_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rst_access drop: got req=%b ready=%b want req=0 ready=1", ob_req, ob_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin ack32 = 1'b1; rdata = 64'hFFFF_FFFF; end
      @(posedge clk); #1;
      ack32 = 1'b0;
      checks++;
      if ({ob_ready, ob_valid, ob_req} !== 3'b100) begin
        errors++;
        $display("FAIL rst_access after c%0d: got ready=%b valid=%b req=%b want 1 0 0",
                 i, ob_ready, ob_valid, ob_req);
      end
    end
  endtask

  task automatic test_stray_ack;
    wide = 1'b0; ack32 = 1'b1; rdata = 64'h5555_5555;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({ob_valid, ob_ready, ob_req} !== 3'b010) begin
        errors++;
        $display("FAIL stray_ack c%0d: got valid=%b ready=%b req=%b want 0 1 0",
                 i, ob_valid, ob_ready, ob_req);
      end
    end
    ack32 = 1'b0;
    run_op(0, 5'd18, 1, 64'h5006, 64'd0, 1, 0, 3'b101, 2, 64'hBEEF_0000, 1, 64'h0000_BEEF, "lhu_after_stray");
  endtask

  task automatic test_back_to_back;
    logic [63:0] vals [4];
    wide = 1'b0; is_ld = 1'b0; is_st = 1'b0; f3 = 3'd0;
    for (int i = 0; i < 4; i++) vals[i] = {32'd0, $urandom};
    for (int i = 0; i < 4; i++) begin
      rd_addr = 5'(20 + i); wreg = 1'(i % 2); wdata = vals[i]; v32 = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({ob_valid, ob_ready, ob_rd, ob_wreg, ob_res} !== {1'b1, 1'b1, 5'(20 + i), 1'(i % 2), vals[i]}) begin
        errors++;
        $display("FAIL b2b %0d: got valid=%b ready=%b rd=%0d wreg=%b wd=%h want 1 1 %0d %b %h",
                 i, ob_valid, ob_ready, ob_rd, ob_wreg, ob_res, 20 + i, 1'(i % 2), vals[i]);
      end
    end
    v32 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ob_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b tail: got valid=%b want 0", ob_valid);
    end
  endtask

  task automatic test_random;
    bit          w;
    int          kind;
    logic [63:0] wd;
    for (int n = 0; n < 60; n++) begin
      w    = (n >= 40);
      kind = int'($urandom_range(0, 2));
      wd   = {$urandom, $urandom};
      run_op(w, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), wd,
             {$urandom, $urandom}, kind == 1, kind == 2, 3'($urandom_range(0, 7)),
             int'($urandom_range(0, 3)), {$urandom, $urandom}, 0, 64'd0,
             $sformatf("rnd%0d", n));
    end
  endtask

  initial begin
    rst = 1'b1; wide = 1'b0;
    v32 = 1'b0; v64 = 1'b0; ack32 = 1'b0; ack64 = 1'b0;
    rd_addr = '0; wreg = 1'b0; is_ld = 1'b0; is_st = 1'b0;
    wdata = '0; sdata = '0; rdata = '0; f3 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    test_reset;
    @(posedge clk); #1;
    test_alu;
    test_load;
    test_store;
    test_misalign;
    test_wide;
    test_back_to_back;
    test_stray_ack;
    test_rst_access;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Parametrised memory-access pipeline stage for the XPU core. It sits between EX and WB and performs loads and stores against the data RAM through a req/ack handshake, with byte-lane steering, sign/zero extension and an EX-side stall. Results are registered into the MEM/WB boundary. It also drives a forwarding path back to ID.

## Interface
- `DATA_W`, 32: register/data width, 32 or 64.
- `REG_ADDR_W`, 5: register address width.
- `ADDR_W`, 32: data RAM byte-address width.

Ports:
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `valid_i` input 1: EX presents an instruction.
- `ready_o` output 1: stage can accept; high only in IDLE.
- `rd_addr_i` input REG_ADDR_W: destination register.
- `wreg_i` input 1: instruction writes rd.
- `wdata_i` input DATA_W: ALU result; effective address for loads/stores (low ADDR_W bits).
- `store_data_i` input DATA_W: rs2 value for stores.
- `is_load_i` / `is_store_i` input 1 each: access type; never both high.
- `funct3_i` input 3: access size/sign.
- `dram_req_o` output 1: RAM request.
- `dram_we_o` output 1: 1 = store.
- `dram_addr_o` output ADDR_W: word-aligned address (low log2(DATA_W/8) bits zero).
- `dram_be_o` output DATA_W/8: byte enables.
- `dram_wdata_o` output DATA_W: lane-shifted store data.
- `dram_ack_i` input 1: RAM completes; `dram_rdata_i` valid that cycle.
- `dram_rdata_i` input DATA_W: full RAM word.
- `valid_o` output 1: one-cycle pulse; WB fields valid.
- `rd_addr_o` output REG_ADDR_W, `wreg_o` output 1, `wdata_o` output DATA_W: registered WB fields.
- `mem_back_rd_addr_o` output REG_ADDR_W, `mem_back_wreg_o` output 1, `mem_back_wdata_o` output DATA_W: combinational forward to ID.
- `stall_o` output 1: `~ready_o`.
- `misalign_o` output 1: one-cycle pulse on a misaligned access.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE, `valid_i` high, no memory op: latch rd/wreg/wdata; next cycle `valid_o`=1; stay IDLE.
- IDLE, `valid_i` high, load/store, aligned: latch fields; go to ACCESS.
- ACCESS: `dram_req_o`=1 with address, we, be and wdata held stable until the `dram_ack_i` cycle.
- `dram_ack_i` in ACCESS: a load captures the extracted and extended data; go to RESP.
- RESP: `valid_o`=1 for one cycle; return to IDLE.
- Stores always give `wreg_o`=0.
- funct3 encodings:
  - 000 = B
  - 001 = H
  - 010 = W
  - 100 = BU
  - 101 = HU
  - 011 = D and 110 = WU, legal only when DATA_W=64; otherwise treated as misaligned.
- Byte lane = address mod (DATA_W/8). Loads right-shift by lane×8, then sign- or zero-extend to DATA_W. Stores replicate data across lanes; be = size mask << lane.
- Forward path: `mem_back_*` = `rd_addr_i`, `wdata_i`, and `wreg_i & valid_i & ~is_load_i`. A load result is never forwarded from this stage.

## Timing
- Reset values: all outputs 0, except `ready_o`=1; state IDLE; latched fields 0.
- Non-memory latency: 1 cycle from acceptance to `valid_o`.
- Memory latency: acceptance, then ACCESS (≥1 cycle; N cycles of ack wait), then RESP. Total = N+2 cycles.
- `dram_ack_i` outside ACCESS is ignored.
- `rst` during ACCESS drops `dram_req_o` immediately and discards the instruction; no `valid_o` follows.
- The RAM must tolerate an abandoned request.
- Back-to-back accepts are possible only in IDLE. Throughput is 1/cycle for non-memory ops.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - H at odd address, or W/D not naturally aligned: no RAM request.
  - `misalign_o` pulses with `valid_o` after one cycle; `wreg_o`=0.
- Undefined:
  - `misalign_o` tied 0.
  - Offending low address bits are cleared (access rounds down) and the access proceeds normally.
  - Illegal funct3 is treated as W.

## Test plan
- ALU op: rd=5, wdata=0x1234 → next cycle `valid_o`=1, `rd_addr_o`=5, `wdata_o`=0x1234. Same cycle: `mem_back_wreg_o`=1.
- LB at 0x1003, RAM word 0x80FF_FF00, ack after 3 cycles → `wdata_o`=0xFFFF_FF80. LBU at the same address → 0x80. `stall_o` high for 5 cycles.
- SH at 0x2002, data 0xABCD → `dram_be_o`=0b1100, `dram_wdata_o`=0xABCD_ABCD, `dram_we_o`=1. On completion, `wreg_o`=0.
- LW at 0x3001 with `MEM_MISALIGN_TRAP_EN` → no `dram_req_o`; `misalign_o`=1 and `valid_o`=1 next cycle. Without the macro → request at 0x3000.
- Assert `rst` during ACCESS → `dram_req_o`=0 within the same cycle. After release: IDLE, `ready_o`=1, no `valid_o`.
- DATA_W=64, LWU at 0x...4, word 0xFFFF_FFFF_0000_0000 → `wdata_o`=0x0000_0000_FFFF_FFFF.
